operand_register_file: RTL and testbench
========================================

# operand_register_file

Eight-word 16-bit register file that sources the two ALU operand buses. It holds four general registers (R1–R4) and four scratch registers (S1–S4). Each register executes a per-cycle micro-operation (load, clear, increment, decrement, byte load, sign-extend) on the `I` bus. Two independent combinational read ports drive the ALU inputs `A` and `B`. `I` is normally driven by the ALU result, a memory word or an immediate.

## Interface
- `WIDTH`, 16: register and bus width; byte ops use `WIDTH/2`.
- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high; clears all eight registers at the rising edge.
- `I`  in  16  write-data bus.
- `FunSel`  in  3  micro-operation applied to every enabled register this cycle.
- `RegSel`  in  4  active-high enables; bit0 = R1 … bit3 = R4; any combination is legal.
- `ScrSel`  in  4  active-high enables; bit0 = S1 … bit3 = S4; any combination is legal.
- `OutASel`  in  3  read select for `OutA`: 000–011 = R1–R4, 100–111 = S1–S4.
- `OutBSel`  in  3  read select for `OutB`, same encoding as `OutASel`.
- `OutA`  out  16  contents of the register selected by `OutASel`; drives ALU `A`.
- `OutB`  out  16  contents of the register selected by `OutBSel`; drives ALU `B`.

## Operation
- FunSel encodings (result written to each enabled register Q):
  - 000 DEC: Q−1 mod 2^16 (0x0000 → 0xFFFF).
  - 001 INC: Q+1 mod 2^16 (0xFFFF → 0x0000).
  - 010 LOAD: I.
  - 011 CLEAR: 0x0000.
  - 100 LOADLZ: {8'h00, I[7:0]}.
  - 101 LOADLO: {Q[15:8], I[7:0]}.
  - 110 LOADHI: {I[7:0], Q[7:0]}.
  - 111 SEXT: {{8{I[7]}}, I[7:0]}.
- Registers with a cleared enable bit hold their value. FunSel is ignored when all 8 enables are 0.
- Several enabled registers each apply FunSel to their own prior value. With INC, R1 = 3 and S2 = 9 become 4 and 10.
- No flags are produced. Flags are owned by the ALU downstream.
- Read ports are pure muxes with no enables. `OutASel` and `OutBSel` may select the same register, and both outputs then carry the same value.
- Arithmetic is unsigned modulo 2^16 with no saturation. `I[15:8]` is ignored by modes 100–111.

## Timing
- Reset value: all registers 0x0000, so `OutA` = `OutB` = 0x0000 for any select.
- Reset has priority over every enable and FunSel. Assertion mid-sequence discards that cycle's operation, and the next edge with Reset low resumes normally from 0.
- Write latency is one edge: an operation set up in cycle k is visible on `OutA`/`OutB` after edge k.
- Read latency is zero: a select change is reflected combinationally in the same cycle.
- Read-during-write: before the edge the outputs show the old value; after the edge they show the new value. There is no bypass from `I`.
- An ALU-result write-back loop (I ← ALUOut, OutA → A) is therefore one operation per cycle with no combinational loop through registers.
- No handshake; the control unit guarantees stable selects before the edge.

## Structure
- Shared package `cpu_pkg`:
  - FunSel localparams `RF_DEC`, `RF_INC`, `RF_LOAD`, `RF_CLR`, `RF_LOADLZ`, `RF_LOADLO`, `RF_LOADHI`, `RF_SEXT`.
  - Read-select codes `SEL_R1`…`SEL_S4`.
  - `WIDTH` default.
  - These are reused by the control unit and by the ALU bench.
- Sub-module `word_register`:
  - Ports: `Clock`, `Reset`, `E`, `FunSel[2:0]`, `I[15:0]`, `Q[15:0]`.
  - Implements the eight micro-operations.
  - Instantiated 8×. The top level adds only the enable fan-out and the two 8:1 read muxes.

## Test plan
1. **Reset dominance:** Reset=1, RegSel=1111, ScrSel=1111, FunSel=010, I=0x1234, one edge → every select reads 0x0000 on both ports.
2. **Parallel load:** RegSel=0001, ScrSel=0100, FunSel=010, I=0xBEEF, one edge → OutASel=000 gives 0xBEEF and OutBSel=110 gives 0xBEEF; the other six registers read 0x0000.
3. **Wrap-around on R2:** CLEAR then DEC → 0xFFFF; INC → 0x0000; INC → 0x0001.
4. **Byte ops on R3 starting at 0x1234:**
   - LOADLO, I=0x77AB → 0x12AB.
   - LOADHI, I=0x00CD → 0xCDAB.
   - LOADLZ, I=0xFF80 → 0x0080.
   - SEXT, I=0x0080 → 0xFF80.
   - SEXT, I=0x007F → 0x007F.
5. **Read-during-write on R4:** R4=0x0005, INC, OutASel=OutBSel=011 → both outputs read 0x0005 before the edge and 0x0006 after; the next cycle with RegSel=0000 holds 0x0006.
6. **Reset mid-stream on S1:** INC every cycle from 0 with Reset pulsed high during the 3rd cycle → S1 reads 1, 2, 0, then 1 and 2 on the following edges.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file micro-operation codes, read-select codes
// and the default datapath width used by the control unit, ALU and register file.
package cpu_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] RF_DEC    = 3'b000;
    localparam logic [2:0] RF_INC    = 3'b001;
    localparam logic [2:0] RF_LOAD   = 3'b010;
    localparam logic [2:0] RF_CLR    = 3'b011;
    localparam logic [2:0] RF_LOADLZ = 3'b100;
    localparam logic [2:0] RF_LOADLO = 3'b101;
    localparam logic [2:0] RF_LOADHI = 3'b110;
    localparam logic [2:0] RF_SEXT   = 3'b111;

    localparam logic [2:0] SEL_R1 = 3'b000;
    localparam logic [2:0] SEL_R2 = 3'b001;
    localparam logic [2:0] SEL_R3 = 3'b010;
    localparam logic [2:0] SEL_R4 = 3'b011;
    localparam logic [2:0] SEL_S1 = 3'b100;
    localparam logic [2:0] SEL_S2 = 3'b101;
    localparam logic [2:0] SEL_S3 = 3'b110;
    localparam logic [2:0] SEL_S4 = 3'b111;

endpackage

// File: rtl/word_register.sv
// One register-file word: applies the selected micro-operation to its own
// contents on each enabled rising edge.
module word_register
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q
);

    localparam int HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] next_q;

    // Byte modes use only the low half of I; the upper half of the bus is ignored.
    always_comb begin
        next_q = Q;
        case (FunSel)
            RF_DEC:    next_q = Q - ONE;
            RF_INC:    next_q = Q + ONE;
            RF_LOAD:   next_q = I;
            RF_CLR:    next_q = '0;
            RF_LOADLZ: next_q = {{(WIDTH-HALF){1'b0}}, I[HALF-1:0]};
            RF_LOADLO: next_q = {Q[WIDTH-1:HALF], I[HALF-1:0]};
            RF_LOADHI: next_q = {I[HALF-1:0], Q[HALF-1:0]};
            RF_SEXT:   next_q = {{(WIDTH-HALF){I[HALF-1]}}, I[HALF-1:0]};
            default:   next_q = Q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (E) begin
            Q <= next_q;
        end
    end

endmodule

// File: rtl/operand_register_file.sv
// Eight-word operand register file (R1-R4, S1-S4) feeding the ALU A/B buses
// through two independent combinational read ports.
module operand_register_file
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);

    // Index order matches the read-select encoding: 0-3 = R1-R4, 4-7 = S1-S4.
    logic [7:0]       enables;
    logic [WIDTH-1:0] words [8];

    assign enables = {ScrSel, RegSel};

    for (genvar g = 0; g < 8; g++) begin : g_word
        word_register #(
            .WIDTH (WIDTH)
        ) u_word (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (enables[g]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (words[g])
        );
    end

    // No bypass from I: reads always reflect the registered contents.
    assign OutA = words[OutASel];
    assign OutB = words[OutBSel];

endmodule

// File: tb/tb_operand_register_file.sv
// Directed bench for operand_register_file with hand-computed expected values.
module tb_operand_register_file;
    import cpu_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [15:0] OutA;
    logic [15:0] OutB;

    int tests_run = 0;
    int tests_failed = 0;

    operand_register_file #(.WIDTH(16)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Read one register through both ports and check both.
    task automatic read_both(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        OutASel = sel;
        OutBSel = sel;
        #1;
        check({tag, "_A"}, OutA, exp);
        check({tag, "_B"}, OutB, exp);
    endtask

    task automatic idle();
        RegSel = 4'b0000;
        ScrSel = 4'b0000;
    endtask

    initial begin
        Reset = 1'b0; I = 16'h0000; FunSel = RF_LOAD;
        RegSel = 4'b0000; ScrSel = 4'b0000; OutASel = SEL_R1; OutBSel = SEL_R1;
        #2;

        // 1. Reset dominates a full-width load
        Reset = 1'b1; RegSel = 4'b1111; ScrSel = 4'b1111; FunSel = RF_LOAD; I = 16'h1234;
        tick();
        Reset = 1'b0; idle();
        for (int s = 0; s < 8; s++) read_both($sformatf("rst_sel%0d", s), 3'(s), 16'h0000);

        // 2. Parallel load of R1 and S3
        RegSel = 4'b0001; ScrSel = 4'b0100; FunSel = RF_LOAD; I = 16'hBEEF;
        tick();
        idle();
        OutASel = SEL_R1; OutBSel = SEL_S3; #1;
        check("pload_R1_A", OutA, 16'hBEEF);
        check("pload_S3_B", OutB, 16'hBEEF);
        for (int s = 0; s < 8; s++) begin
            if (s != 0 && s != 6) begin
                OutASel = 3'(s); #1;
                check($sformatf("pload_other%0d", s), OutA, 16'h0000);
            end
        end

        // 3. Wrap-around on R2
        OutASel = SEL_R2; OutBSel = SEL_R2;
        RegSel = 4'b0010; FunSel = RF_CLR; tick();
        FunSel = RF_DEC; tick(); check("wrap_dec", OutA, 16'hFFFF);
        FunSel = RF_INC; tick(); check("wrap_inc0", OutA, 16'h0000);
        FunSel = RF_INC; tick(); check("wrap_inc1", OutB, 16'h0001);
        idle();

        // 4. Byte operations on R3
        OutASel = SEL_R3; OutBSel = SEL_R3;
        RegSel = 4'b0100;
        FunSel = RF_LOAD;   I = 16'h1234; tick(); check("byte_init",   OutA, 16'h1234);
        FunSel = RF_LOADLO; I = 16'h77AB; tick(); check("byte_loadlo", OutA, 16'h12AB);
        FunSel = RF_LOADHI; I = 16'h00CD; tick(); check("byte_loadhi", OutA, 16'hCDAB);
        FunSel = RF_LOADLZ; I = 16'hFF80; tick(); check("byte_loadlz", OutA, 16'h0080);
        FunSel = RF_SEXT;   I = 16'h0080; tick(); check("byte_sext_n", OutA, 16'hFF80);
        FunSel = RF_SEXT;   I = 16'h007F; tick(); check("byte_sext_p", OutA, 16'h007F);
        idle();

        // 5. Read-during-write on R4
        RegSel = 4'b1000; FunSel = RF_LOAD; I = 16'h0005; tick();
        FunSel = RF_INC; I = 16'hAAAA;
        read_both("rdw_before", SEL_R4, 16'h0005);
        tick();
        read_both("rdw_after", SEL_R4, 16'h0006);
        idle(); tick();
        read_both("rdw_hold", SEL_R4, 16'h0006);

        // 6. Reset pulsed mid-stream while S1 increments
        OutASel = SEL_S1; OutBSel = SEL_S1;
        ScrSel = 4'b0001; FunSel = RF_INC;
        tick(); check("mid_c1", OutA, 16'h0001);
        tick(); check("mid_c2", OutA, 16'h0002);
        Reset = 1'b1; tick(); check("mid_rst", OutA, 16'h0000);
        Reset = 1'b0;
        tick(); check("mid_c4", OutA, 16'h0001);
        tick(); check("mid_c5", OutB, 16'h0002);
        idle();

        // 7. Simultaneous INC of R1 and S2, each from its own value
        RegSel = 4'b0001; FunSel = RF_LOAD; I = 16'h0003; tick();
        RegSel = 4'b0000; ScrSel = 4'b0010; I = 16'h0009; tick();
        RegSel = 4'b0001; ScrSel = 4'b0010; FunSel = RF_INC; I = 16'h0000; tick();
        idle();
        OutASel = SEL_R1; OutBSel = SEL_S2; #1;
        check("multi_R1", OutA, 16'h0004);
        check("multi_S2", OutB, 16'h000A);
        OutASel = SEL_S1; #1;
        check("multi_S1_hold", OutA, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
